// File: rtl/io_map_pkg.sv
// Shared definitions for the MCU output-port peripherals: default port IDs,
// UART transmitter state encoding and status byte layout.
package io_map_pkg;

   localparam logic [7:0] TX_DATA_ID_DEF = 8'h40;
   localparam logic [7:0] STATUS_ID_DEF  = 8'h41;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

   localparam int unsigned STAT_BUSY_BIT    = 0;
   localparam int unsigned STAT_FULL_BIT    = 1;
   localparam int unsigned STAT_OVERRUN_BIT = 2;

   // Status byte as seen on the MCU input-port path: {5'b0, OVERRUN, FULL, BUSY}
   function automatic logic [7:0] status_byte(input logic overrun, input logic full,
                                              input logic busy);
      logic [7:0] s;
      s                   = 8'h00;
      s[STAT_BUSY_BIT]    = busy;
      s[STAT_FULL_BIT]    = full;
      s[STAT_OVERRUN_BIT] = overrun;
      return s;
   endfunction

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO with show-ahead read data. Writes when full and reads
// when empty are ignored; fullness is always judged on the pre-edge count.
module tx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_wr, do_rd;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

   // Storage array; contents need no reset since occupancy gates every read
   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MCU output-port bus. Bytes written
// to TX_DATA_ID are queued and shifted out LSB first; STATUS_ID reads status
// and a strobe to it clears the sticky overrun flag.
module io_uart_tx
   import io_map_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [7:0]  TX_DATA_ID   = TX_DATA_ID_DEF,
   parameter logic [7:0]  STATUS_ID    = STATUS_ID_DEF,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] PORT_ID,
   input  logic [7:0] OUT_PORT,
   input  logic       IO_STRB,
   output logic [7:0] IN_PORT_DATA,
   output logic       TX,
   output logic       BUSY,
   output logic       FULL
);

   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   uart_tx_state_t state_q, state_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [7:0]     shift_q, shift_d;
   logic           tx_q, tx_d;
   logic           overrun_q, overrun_d;

   logic                      wr_req, clr_req, pop, baud_end;
   logic [7:0]                fifo_rd_data;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                      fifo_full, fifo_empty;

   assign wr_req   = IO_STRB && (PORT_ID == TX_DATA_ID);
   assign clr_req  = IO_STRB && (PORT_ID == STATUS_ID);
   assign baud_end = (baud_q == BAUD_LAST);

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .wr_en   (wr_req),
      .wr_data (OUT_PORT),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Frame sequencer: start bit, 8 data bits, stop bit, chaining straight into the next frame
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_rd_data;
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d    = '0;
               bit_idx_d = 3'd0;
               state_d   = DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d    = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_rd_data;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level follows the current state one cycle later, keeping every bit the same length
   always_comb begin
      tx_d = 1'b1;
      if (state_q == START)     tx_d = 1'b0;
      else if (state_q == DATA) tx_d = shift_q[0];
   end

   // Sticky overrun: a dropped write wins over a clear on the same edge
   always_comb begin
      overrun_d = overrun_q;
      if (clr_req)              overrun_d = 1'b0;
      if (wr_req && fifo_full)  overrun_d = 1'b1;
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         overrun_q <= overrun_d;
      end
   end

   assign TX   = tx_q;
   assign BUSY = (state_q != IDLE) || (fifo_count != '0);
   assign FULL = fifo_full;
   assign IN_PORT_DATA = (PORT_ID == STATUS_ID) ? status_byte(overrun_q, FULL, BUSY) : 8'h00;

endmodule
